clarvi_mem_arbiter: RTL

//  Shares one Avalon-MM pipelined-read master port between the core's instruction-fetch

---
 rtl/clarvi_mem_arbiter_pkg.sv | 12 +
 rtl/clarvi_tag_fifo.sv | 56 +++++
 rtl/clarvi_mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/clarvi_mem_arbiter_pkg.sv
// Shared types for the clarvi memory arbiter: requester tag and arbitration state.
// Types only; no latency or backpressure of its own.
package clarvi_mem_arbiter_pkg;

  typedef enum logic {REQ_INSTR = 1'b0, REQ_MAIN = 1'b1} mem_requester_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_INSTR, ARB_LOCK_MAIN} arb_state_t;

  localparam int WORD_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

endpackage

// File: rtl/clarvi_tag_fifo.sv
// Circular tag buffer recording the owner of each outstanding read; pop data is the oldest entry.
// One-cycle push-to-visible latency, no bypass; pushes when full and pops when empty are ignored.
module clarvi_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Merges the fetch and data ports onto one pipelined-read master; zero-cycle grant and response paths.
// Grant locks while the slave waits; reads stall at MAX_PENDING outstanding; losers see wait=1.
module clarvi_mem_arbiter
  import clarvi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 30,
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] instr_address,
  input  logic                  instr_read,
  output logic                  instr_wait,
  output logic [WORD_WIDTH-1:0] instr_read_data,
  output logic                  instr_read_data_valid,
  input  logic [ADDR_WIDTH-1:0] main_address,
  input  logic [BE_WIDTH-1:0]   main_byte_enable,
  input  logic                  main_read,
  input  logic                  main_write,
  input  logic [WORD_WIDTH-1:0] main_write_data,
  output logic                  main_wait,
  output logic [WORD_WIDTH-1:0] main_read_data,
  output logic                  main_read_data_valid,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [BE_WIDTH-1:0]   avm_byte_enable,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [WORD_WIDTH-1:0] avm_write_data,
  input  logic                  avm_wait,
  input  logic [WORD_WIDTH-1:0] avm_read_data,
  input  logic                  avm_read_data_valid,
  output logic                  protocol_error
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t     state, state_next;
  logic [SW-1:0]  starve_cnt;
  logic [CW-1:0]  pend_cnt;
  logic           fifo_full, fifo_empty, tag_raw;
  logic           reads_blocked, instr_ok, main_ok, starved;
  logic           grant_instr, grant_main, instr_accept, push, pop;
  mem_requester_t pop_tag;

  always_comb begin
    reads_blocked = (pend_cnt == CW'(MAX_PENDING));
    instr_ok      = instr_read & ~reads_blocked;
    main_ok       = main_write | (main_read & ~reads_blocked);
    starved       = (starve_cnt == SW'(STARVE_LIMIT));
    grant_instr   = 1'b0;
    grant_main    = 1'b0;
    state_next    = state;
    if (reset_n) begin
      case (state)
        ARB_IDLE: begin
          // A starved fetch only pre-empts main when it can actually issue.
          if (main_ok && !(starved && instr_ok)) grant_main = 1'b1;
          else if (instr_ok)                     grant_instr = 1'b1;
          if (avm_wait && grant_main)       state_next = ARB_LOCK_MAIN;
          else if (avm_wait && grant_instr) state_next = ARB_LOCK_INSTR;
        end
        ARB_LOCK_INSTR: begin
          grant_instr = instr_ok;
          if (!avm_wait) state_next = ARB_IDLE;
        end
        ARB_LOCK_MAIN: begin
          grant_main = main_ok;
          if (!avm_wait) state_next = ARB_IDLE;
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  assign avm_address     = grant_main ? main_address : instr_address;
  assign avm_byte_enable = grant_main ? main_byte_enable : '1;
  assign avm_read        = grant_instr | (grant_main & main_read);
  assign avm_write       = grant_main & main_write;
  assign avm_write_data  = main_write_data;
  assign instr_wait      = ~grant_instr | avm_wait;
  assign main_wait       = ~grant_main | avm_wait;
  assign instr_accept    = grant_instr & ~avm_wait;

  assign push    = avm_read & ~avm_wait;
  assign pop     = reset_n & avm_read_data_valid & ~fifo_empty;
  assign pop_tag = mem_requester_t'(tag_raw);

  // Data fans out to both ports; only the valid is steered by the oldest tag.
  assign instr_read_data       = avm_read_data;
  assign main_read_data        = avm_read_data;
  assign instr_read_data_valid = pop & (pop_tag == REQ_INSTR);
  assign main_read_data_valid  = pop & (pop_tag == REQ_MAIN);

  clarvi_tag_fifo #(.DEPTH(MAX_PENDING), .WIDTH(1)) u_tag_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (grant_main),
    .pop       (pop),
    .pop_data  (tag_raw),
    .count     (pend_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= ARB_IDLE;
      starve_cnt     <= '0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_next;
      if (instr_accept)               starve_cnt <= '0;
      else if (instr_read && !starved) starve_cnt <= starve_cnt + 1'b1;
      if (avm_read_data_valid && fifo_empty) protocol_error <= 1'b1;
    end
  end

  pend_consistent: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_full == reads_blocked);

endmodule
